display_share_arbiter: RTL and testbench

- Shares the board's single 4-digit multiplexed 7-segment display between two requesters (for example, the mod-1000 counter and a status/message source).
- Grants ownership with a round-robin policy and a minimum hold time.
- Blanks the display for a guard interval on every ownership change.
- Scans the owner's 0-999 value across the three right-hand digits. It sits between the requesters and the board-level Anode_Activate/seg_out pins.

---
 rtl/display_share_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_display_share_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_share_arbiter.sv
// Display share arbiter: two requesters take turns driving the single
// 4-digit multiplexed 7-segment display. Ownership is granted round-robin
// with a minimum hold time, every hand-over blanks the display for a guard
// interval, and the owner's 0-999 value is scanned across the three
// right-hand digits (the leftmost digit stays dark).
//
// Request semantics: req0/req1 are levels, not pulses. A requester keeps its
// req high for as long as it wants the display and is told it owns it by
// the one-hot grant. There is no per-transfer handshake: val0/val1 are
// sampled only at grant time and at frame boundaries.
module display_share_arbiter #(
    parameter int SCAN_DIV    = 100000,
    parameter int HOLD_TICKS  = 2000,
    parameter int BLANK_TICKS = 4
) (
    input  logic       clk_100Mhz,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [9:0] val0,
    input  logic [9:0] val1,
    output logic [1:0] grant,
    output logic [3:0] Anode_Activate,
    output logic [0:6] seg_out,
    output logic [1:0] fsm_state
);

    localparam int SCAN_W  = $clog2(SCAN_DIV + 1);
    localparam int HOLD_W  = $clog2(HOLD_TICKS + 1);
    localparam int BLANK_W = $clog2(BLANK_TICKS + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_OWN0   = 2'd1;
    localparam logic [1:0] ST_OWN1   = 2'd2;
    localparam logic [1:0] ST_SWITCH = 2'd3;

    logic [SCAN_W-1:0]  scan_cnt;
    logic [1:0]         digit_idx;
    logic               scan_tick;
    logic               frame_end;

    logic [1:0]         state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [BLANK_W-1:0] blank_cnt;
    logic [BLANK_W:0]   blank_nxt;
    logic               blank_done;
    logic               last_owner;
    logic [9:0]         disp_val;

    logic               any_req;
    logic               win;
    logic [9:0]         win_val;
    logic               own_id;
    logic               own_req;
    logic               other_req;
    logic [9:0]         own_val;
    logic               hold_full;

    logic [3:0]         an_nxt;
    logic [6:0]         seg_nxt;
    logic [3:0]         digit;
    logic               over_range;

    assign fsm_state = state;

    // Standard active-low a..g pattern, segment a in the MSB.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    assign scan_tick = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    assign frame_end = scan_tick && (digit_idx == 2'd3);

    // Free-running digit-slot timebase and digit index.
    always_ff @(posedge clk_100Mhz or negedge reset) begin
        if (!reset) begin
            scan_cnt  <= '0;
            digit_idx <= 2'd0;
        end else begin
            scan_cnt <= scan_tick ? '0 : scan_cnt + SCAN_W'(1);
            if (scan_tick) begin
                digit_idx <= digit_idx + 2'd1;
            end
        end
    end

    // Arbitration and owner bookkeeping, shared by IDLE and end of SWITCH.
    always_comb begin
        any_req    = req0 | req1;
        // On a tie the requester that did not own last wins; otherwise the
        // lone requester wins.
        win        = (req0 && req1) ? ~last_owner : req1;
        win_val    = win ? val1 : val0;
        own_id     = (state == ST_OWN1);
        own_req    = own_id ? req1 : req0;
        other_req  = own_id ? req0 : req1;
        own_val    = own_id ? val1 : val0;
        hold_full  = (hold_cnt == HOLD_W'(HOLD_TICKS));
        blank_nxt  = {1'b0, blank_cnt} + (BLANK_W + 1)'(scan_tick);
        blank_done = (blank_nxt >= (BLANK_W + 1)'(BLANK_TICKS));
    end

    // Ownership FSM: grant, hold/guard counters, last owner and frame value.
    always_ff @(posedge clk_100Mhz or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            grant      <= 2'b00;
            hold_cnt   <= '0;
            blank_cnt  <= '0;
            last_owner <= 1'b1;
            disp_val   <= 10'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state    <= win ? ST_OWN1 : ST_OWN0;
                        grant    <= win ? 2'b10 : 2'b01;
                        disp_val <= win_val;
                        hold_cnt <= '0;
                    end
                end
                ST_OWN0, ST_OWN1: begin
                    if (scan_tick && !hold_full) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                    // The value only moves on a frame boundary so a frame
                    // never mixes digits of two different values.
                    if (frame_end) begin
                        disp_val <= own_val;
                    end
                    if (!own_req || (hold_full && other_req)) begin
                        state      <= ST_SWITCH;
                        grant      <= 2'b00;
                        last_owner <= own_id;
                        blank_cnt  <= '0;
                    end
                end
                ST_SWITCH: begin
                    blank_cnt <= blank_nxt[BLANK_W-1:0];
                    // Requests are looked at only once the guard has elapsed.
                    if (blank_done) begin
                        if (any_req) begin
                            state    <= win ? ST_OWN1 : ST_OWN0;
                            grant    <= win ? 2'b10 : 2'b01;
                            disp_val <= win_val;
                            hold_cnt <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

    // Digit decode for the current slot; dark unless someone owns the display.
    always_comb begin
        an_nxt     = 4'b1111;
        seg_nxt    = 7'b1111111;
        digit      = 4'd0;
        over_range = (disp_val >= 10'd1000);
        if (state == ST_OWN0 || state == ST_OWN1) begin
            case (digit_idx)
                2'd0: begin
                    an_nxt = 4'b1110;
                    digit  = 4'(disp_val % 10'd10);
                end
                2'd1: begin
                    an_nxt = 4'b1101;
                    digit  = 4'((disp_val / 10'd10) % 10'd10);
                end
                2'd2: begin
                    an_nxt = 4'b1011;
                    digit  = 4'(disp_val / 10'd100);
                end
                default: begin
                    an_nxt = 4'b1111;
                end
            endcase
            if (digit_idx != 2'd3) begin
                seg_nxt = over_range ? 7'b1111110 : seg7(digit);
            end
        end
    end

    // Registered pin drivers, one cycle behind the digit index.
    always_ff @(posedge clk_100Mhz or negedge reset) begin
        if (!reset) begin
            Anode_Activate <= 4'b1111;
            seg_out        <= 7'b1111111;
        end else begin
            Anode_Activate <= an_nxt;
            seg_out        <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_display_share_arbiter.sv
// Bench for display_share_arbiter with a fast timebase. A reference model
// driven from a cycle count and scan-tick arithmetic predicts grant, anodes
// and segments for every clock; a monitor compares them on the falling edge.
module tb_display_share_arbiter;

    localparam int S = 4;
    localparam int H = 8;
    localparam int B = 4;
    localparam logic [12:0] RESET_OUT = {2'b00, 4'b1111, 7'b1111111};

    // ---------------- clock / reset ----------------
    logic       clk_100Mhz = 1'b0;
    logic       reset      = 1'b1;
    logic       req0, req1;
    logic [9:0] val0, val1;
    logic [1:0] grant;
    logic [3:0] Anode_Activate;
    logic [0:6] seg_out;
    logic [1:0] fsm_state;

    always #5 clk_100Mhz = ~clk_100Mhz;

    display_share_arbiter #(
        .SCAN_DIV   (S),
        .HOLD_TICKS (H),
        .BLANK_TICKS(B)
    ) dut (
        .clk_100Mhz    (clk_100Mhz),
        .reset         (reset),
        .req0          (req0),
        .req1          (req1),
        .val0          (val0),
        .val1          (val1),
        .grant         (grant),
        .Anode_Activate(Anode_Activate),
        .seg_out       (seg_out),
        .fsm_state     (fsm_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [12:0] exp_q[$];

    task automatic compare(input logic [12:0] exp, input string name);
        logic [12:0] act;
        act = {grant, Anode_Activate, seg_out};
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got grant=%b an=%b seg=%b want grant=%b an=%b seg=%b",
                     name, $time, act[12:11], act[10:7], act[6:0],
                     exp[12:11], exp[10:7], exp[6:0]);
        end
    endtask

    // ---------------- reference model ----------------
    // owner -1 = nobody; guard = display blanked after owner gave it up.
    int m_cyc, m_owner, m_last, m_grant_ticks, m_sw_ticks, m_frame;
    bit m_guard;

    function automatic logic [6:0] pattern(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int pick(input bit r0, input bit r1);
        if (r0 && r1) return 1 - m_last;
        return r1 ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_cyc = 0; m_owner = -1; m_last = 1; m_guard = 0;
        m_grant_ticks = 0; m_sw_ticks = 0; m_frame = 0;
    endtask

    task automatic take(input int w, input int c);
        m_owner       = w;
        m_frame       = (w == 1) ? int'(val1) : int'(val0);
        m_grant_ticks = (c + 1) / S;
    endtask

    task automatic model_step();
        int c, idx, digit, held;
        bit tick, r0, r1, mine, other;
        logic [3:0] an;
        logic [6:0] sg;
        logic [1:0] gr;
        r0 = req0; r1 = req1;
        c = m_cyc;
        tick = ((c % S) == S - 1);
        idx = (c / S) % 4;
        an = 4'b1111;
        sg = 7'b1111111;
        if (m_owner >= 0 && !m_guard && idx != 3) begin
            an = ~(4'b0001 << idx);
            if (m_frame >= 1000) sg = 7'b1111110;
            else begin
                if (idx == 0)      digit = m_frame % 10;
                else if (idx == 1) digit = (m_frame / 10) % 10;
                else               digit = m_frame / 100;
                sg = pattern(digit);
            end
        end
        if (m_owner < 0) begin
            if (r0 || r1) take(pick(r0, r1), c);
        end else if (!m_guard) begin
            held  = c / S - m_grant_ticks;
            mine  = (m_owner == 0) ? r0 : r1;
            other = (m_owner == 0) ? r1 : r0;
            if (tick && idx == 3) m_frame = (m_owner == 0) ? int'(val0) : int'(val1);
            if (!mine || (held >= H && other)) begin
                m_last     = m_owner;
                m_guard    = 1;
                m_sw_ticks = (c + 1) / S;
            end
        end else if ((c + 1) / S - m_sw_ticks >= B) begin
            m_guard = 0;
            m_owner = -1;
            if (r0 || r1) take(pick(r0, r1), c);
        end
        gr = (m_owner >= 0 && !m_guard) ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
        exp_q.push_back({gr, an, sg});
        m_cyc = c + 1;
    endtask

    // Model advances on every active edge; it restarts whenever reset drops.
    always @(posedge clk_100Mhz or negedge reset) begin
        if (!reset) model_reset();
        else        model_step();
    end

    // Monitor: outputs are compared every falling edge.
    always @(negedge clk_100Mhz) begin
        if (!reset) begin
            exp_q.delete();
            compare(RESET_OUT, "in_reset");
        end else if (exp_q.size() == 0) begin
            compare(RESET_OUT, "after_release");
        end else begin
            compare(exp_q.pop_front(), "scan");
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_in(input bit r0, input bit r1, input logic [9:0] v0, input logic [9:0] v1);
        @(posedge clk_100Mhz);
        #1;
        req0 = r0; req1 = r1; val0 = v0; val1 = v1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_100Mhz);
    endtask

    task automatic pulse_reset(input int n);
        @(posedge clk_100Mhz);
        #1 reset = 1'b0;
        repeat (n) @(posedge clk_100Mhz);
        #1 reset = 1'b1;
    endtask

    // Drops reset between edges and checks outputs before any clock edge.
    task automatic async_reset(input string name);
        @(posedge clk_100Mhz);
        #1 reset = 1'b0;
        #1 compare(RESET_OUT, name);
    endtask

    task automatic release_reset();
        @(posedge clk_100Mhz);
        #1 reset = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit         r0, r1;
        logic [9:0] v0, v1;
        req0 = 1'b0; req1 = 1'b0; val0 = 10'd0; val1 = 10'd0;
        #1 reset = 1'b0;
        repeat (5) @(posedge clk_100Mhz);
        #1 reset = 1'b1;
        idle(20);

        // single owner showing 372
        set_in(1, 0, 10'd372, 10'd0);
        idle(40);

        // simultaneous requests after reset, then hold-time pre-emption both ways
        pulse_reset(3);
        set_in(1, 1, 10'd372, 10'd58);
        idle(140);

        // owner gives up early with nobody waiting, later requester 1 arrives
        pulse_reset(3);
        set_in(1, 0, 10'd123, 10'd0);
        idle(11);
        set_in(0, 0, 10'd123, 10'd0);
        idle(30);
        set_in(0, 1, 10'd123, 10'd640);
        idle(30);

        // value changes mid-frame, then out of range
        pulse_reset(3);
        set_in(1, 0, 10'd5, 10'd0);
        idle(6);
        set_in(1, 0, 10'd999, 10'd0);
        idle(40);
        set_in(1, 0, 10'd1000, 10'd0);
        idle(40);

        // reset during the guard interval, release with both requesting
        pulse_reset(3);
        set_in(1, 0, 10'd42, 10'd0);
        idle(10);
        set_in(0, 0, 10'd42, 10'd0);
        idle(3);
        async_reset("reset_in_switch");
        set_in(1, 1, 10'd42, 10'd777);
        release_reset();
        idle(6);

        // owner 0 leaves, requester 1 takes over, reset while it owns
        set_in(0, 1, 10'd42, 10'd777);
        idle(30);
        async_reset("reset_in_own1");
        set_in(1, 1, 10'd314, 10'd777);
        release_reset();
        idle(20);

        // randomized traffic
        r0 = 1'b0; r1 = 1'b0; v0 = 10'd0; v1 = 10'd0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 15) == 0) r0 = ~r0;
            if ($urandom_range(0, 15) == 0) r1 = ~r1;
            if ($urandom_range(0, 31) == 0) v0 = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 31) == 0) v1 = 10'($urandom_range(0, 1023));
            set_in(r0, r1, v0, v1);
            if ($urandom_range(0, 499) == 0) pulse_reset(int'($urandom_range(1, 3)));
        end
        idle(5);

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
